// File: rtl/serial_shift_pkg.sv
// Shared types for the serial shift controller: state encoding and counter width helper.
// The PARITY state exists only when SERIAL_SHIFT_PARITY_EN is defined.
package serial_shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef SERIAL_SHIFT_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_DONE   = 2'd3
  } state_t;

  // Bit counter must be able to hold N (parity cycle index), hence N+1 values.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_reg.sv
// Parallel-in serial-out register: parallel load, shift right with zero fill, synchronous clear.
// Only the LSB is exported since it is the serial output bit.
module piso_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [N-1:0] i_data,
  input  logic         i_shift,
  input  logic         i_clr,
  output logic         o_bit
);

  logic [N-1:0] r_q;

  // Clear has priority so an abort wins over any same-edge shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {1'b0, r_q[N-1:1]};
    end
  end

  assign o_bit = r_q[0];

endmodule

// File: rtl/serial_shift_ctrl.sv
// Serialises an N-bit word LSB first with handshake, abort and one-cycle done pulse.
// Optional trailing even-parity bit when SERIAL_SHIFT_PARITY_EN is defined.
module serial_shift_ctrl
  import serial_shift_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = cnt_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_busy;
  logic             r_ready;
  logic             r_done;
  logic             w_bit;
  logic             w_load;
  logic             w_shift;
  logic             w_clr;
  logic             w_in_xfer;
`ifdef SERIAL_SHIFT_PARITY_EN
  logic             r_par;
`endif

`ifdef SERIAL_SHIFT_PARITY_EN
  assign w_in_xfer = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
`else
  assign w_in_xfer = (r_state == ST_SHIFT);
`endif

  assign w_load  = (r_state == ST_IDLE) && in_valid && !abort;
  assign w_shift = (r_state == ST_SHIFT) && !abort;
  assign w_clr   = w_in_xfer && abort;

  piso_reg #(.N(N)) u_piso (
    .clk     (clk),
    .rst     (reset),
    .i_load  (w_load),
    .i_data  (in_data),
    .i_shift (w_shift),
    .i_clr   (w_clr),
    .o_bit   (w_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
`ifdef SERIAL_SHIFT_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
`ifdef SERIAL_SHIFT_PARITY_EN
            r_par   <= ^in_data;
`endif
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else if (r_cnt == CNT_W'(N - 1)) begin
`ifdef SERIAL_SHIFT_PARITY_EN
            r_state <= ST_PARITY;
            r_cnt   <= CNT_W'(N);
`else
            r_state <= ST_DONE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef SERIAL_SHIFT_PARITY_EN
        ST_PARITY: begin
          r_cnt   <= '0;
          r_valid <= 1'b0;
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          // Abort is deliberately ignored here; completion is already committed.
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_SHIFT_PARITY_EN
  assign sout = r_valid && ((r_state == ST_PARITY) ? r_par : w_bit);
`else
  assign sout = r_valid && w_bit;
`endif

  assign in_ready   = r_ready;
  assign sout_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign bit_cnt    = r_cnt;

endmodule
